uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_baud_tick.sv | 41 ++++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and the baud divisor helper.
// Used by both the TX and RX paths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Clock cycles per bit, rounded to nearest.
  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// User-side byte handshake and serial line of the UART transmitter.
// master: user logic offering bytes; slave: the transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      txd;
  logic                      tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy,
    input  txd
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy,
    output txd
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter shared by the UART TX and RX paths.
// Counts 0..CLKS_PER_BIT-1 while enabled; tick marks the last cycle of each bit period.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_LAST);

  // Next count: clear on request or when idle, wrap at end of bit period.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default, LSB first, registered txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLKS_PER_BIT must be at least 2");
  end

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      txd_q, txd_d;
  logic                      accept;
  logic                      tick;
  logic                      baud_clr;
  logic                      baud_en;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q;
`endif

  assign accept   = bus.tx_valid && (state_q == ST_IDLE);
  assign baud_clr = (state_d != state_q);
  assign baud_en  = (state_q != ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .en  (baud_en),
    .tick(tick)
  );

  // Frame sequencing and shift register next state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shift_d   = bus.tx_data;
          bit_idx_d = 3'd0;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the current state; registered below so txd lags state by one clock.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = parity_q;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  // State, shift register, bit index and output flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= 3'd0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      txd_q     <= txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, taken at capture so later tx_data changes cannot leak in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= ^bus.tx_data;
    end
  end
`endif

  assign bus.txd      = txd_q;
  assign bus.tx_ready = (state_q == ST_IDLE);
  assign bus.tx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=10 (1 MHz clock, 100 kbaud).
// Reference: a frame is a list of line bits each held CPB clocks, starting one clock
// after the accepting edge; tx_ready is low for the whole frame length.
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;
  localparam int CAPN = 512;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if bus();

  uart_tx #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic cap_txd  [CAPN];
  logic cap_rdy  [CAPN];
  logic cap_busy [CAPN];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line bit i of the frame for byte d: start, 8 data LSB first, [even parity], stop.
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    int ones;
    if (i == 0) return 1'b0;
    if (i <= 8) return d[i-1];
    ones = 0;
    for (int b = 0; b < 8; b++) ones += int'(d[b]);
    if (NBITS == 11 && i == 9) return logic'(ones % 2);
    return 1'b1;
  endfunction

  // Frames f=0..nf-1 accepted at capture index f*(FLEN+1).
  function automatic logic exp_txd(input int k, input int nf, input logic [7:0] d0,
                                   input logic [7:0] d1);
    for (int f = 0; f < nf; f++) begin
      int r;
      r = k - f * (FLEN + 1);
      if (r >= 1 && r <= FLEN) return frame_bit((f == 0) ? d0 : d1, (r - 1) / CPB);
    end
    return 1'b1;
  endfunction

  function automatic logic exp_rdy(input int k, input int nf);
    for (int f = 0; f < nf; f++) begin
      int r;
      r = k - f * (FLEN + 1);
      if (r >= 0 && r < FLEN) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Wait (bounded) for ready, offer d, step past the accepting edge. Leaves valid high.
  task automatic start_tx(input logic [7:0] d, input string name);
    int n;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL %s: tx_ready never rose (got %b, need 1)", name, bus.tx_ready);
    end
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    tick();
  endtask

  task automatic capture(input int n, input int drop_k, input int pulse_k,
                         input logic [7:0] pulse_d);
    for (int k = 0; k < n; k++) begin
      cap_txd[k]  = bus.txd;
      cap_rdy[k]  = bus.tx_ready;
      cap_busy[k] = bus.tx_busy;
      if (k == drop_k) bus.tx_valid = 1'b0;
      if (pulse_k >= 0 && k == pulse_k) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = pulse_d;
      end
      if (pulse_k >= 0 && k == pulse_k + 1) bus.tx_valid = 1'b0;
      tick();
    end
  endtask

  task automatic check_capture(input string name, input int n, input int nf,
                               input logic [7:0] d0, input logic [7:0] d1);
    int bad_txd, bad_rdy, bad_busy, first_bad;
    bad_txd = 0; bad_rdy = 0; bad_busy = 0; first_bad = -1;
    for (int k = 0; k < n; k++) begin
      if (cap_txd[k] !== exp_txd(k, nf, d0, d1)) begin
        bad_txd++;
        if (first_bad < 0) first_bad = k;
      end
      if (cap_rdy[k] !== exp_rdy(k, nf)) bad_rdy++;
      if (cap_busy[k] !== ~exp_rdy(k, nf)) bad_busy++;
    end
    checks++;
    if (bad_txd != 0) begin
      failures++;
      $display("FAIL %s txd waveform: %0d bad cycles (first at %0d), need 0", name, bad_txd,
               first_bad);
    end
    checks++;
    if (bad_rdy != 0) begin
      failures++;
      $display("FAIL %s tx_ready waveform: %0d bad cycles, need 0", name, bad_rdy);
    end
    checks++;
    if (bad_busy != 0) begin
      failures++;
      $display("FAIL %s tx_busy waveform: %0d bad cycles, need 0", name, bad_busy);
    end
    // Mid-bit samples of each frame.
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < NBITS; i++) begin
        int k;
        logic want;
        k = f * (FLEN + 1) + 1 + i * CPB + CPB / 2;
        want = frame_bit((f == 0) ? d0 : d1, i);
        checks++;
        if (cap_txd[k] !== want) begin
          failures++;
          $display("FAIL %s frame %0d bit %0d: txd=%b need %b", name, f, i, cap_txd[k], want);
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) tick();
    checks++;
    if (bus.txd !== 1'b1) begin
      failures++;
      $display("FAIL reset txd: got %b need 1", bus.txd);
    end
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset tx_ready: got %b need 1", bus.tx_ready);
    end
    checks++;
    if (bus.tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset tx_busy: got %b need 0", bus.tx_busy);
    end
    rst = 1'b1;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus.txd !== 1'b1 || bus.tx_ready !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle after reset: %0d bad cycles, need 0", bad);
    end
  endtask

  task automatic test_single(input logic [7:0] d, input string name);
    int low;
    start_tx(d, name);
    capture(FLEN + 20, 0, -1, 8'h00);
    check_capture(name, FLEN + 20, 1, d, 8'h00);
    low = 0;
    while (low < FLEN + 20 && cap_rdy[low] === 1'b0) low++;
    checks++;
    if (low != FLEN) begin
      failures++;
      $display("FAIL %s ready-low length: got %0d need %0d", name, low, FLEN);
    end
  endtask

  task automatic test_back_to_back(input logic [7:0] d0, input logic [7:0] d1);
    int rise, restart;
    start_tx(d0, "b2b");
    bus.tx_data = d1;
    capture(2 * FLEN + 20, FLEN + 1, -1, 8'h00);
    check_capture("b2b", 2 * FLEN + 20, 2, d0, d1);
    rise = 0;
    while (rise < CAPN - 1 && cap_rdy[rise] === 1'b0) rise++;
    restart = rise;
    while (restart < CAPN - 1 && cap_rdy[restart] === 1'b1) restart++;
    checks++;
    if (restart - rise != 1) begin
      failures++;
      $display("FAIL b2b restart: ready high for %0d cycles, need 1", restart - rise);
    end
  endtask

  task automatic test_ignore_busy();
    start_tx(8'h00, "ignore_busy");
    bus.tx_valid = 1'b0;
    capture(2 * FLEN + 20, -1, 40, 8'hFF);
    check_capture("ignore_busy", 2 * FLEN + 20, 1, 8'h00, 8'h00);
  endtask

  task automatic test_reset_mid();
    start_tx(8'h0F, "reset_mid");
    bus.tx_valid = 1'b0;
    capture(35, -1, -1, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.txd !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid txd: got %b need 1", bus.txd);
    end
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid tx_ready: got %b need 1", bus.tx_ready);
    end
    repeat (3) tick();
    rst = 1'b1;
    capture(FLEN + 20, -1, -1, 8'h00);
    check_capture("reset_mid idle", FLEN + 20, 0, 8'h00, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      test_single(d, "random");
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    test_single(8'h07, "parity_07");
    checks++;
    if (cap_txd[1 + 9 * CPB + CPB / 2] !== 1'b1) begin
      failures++;
      $display("FAIL parity_07 parity bit: got %b need 1", cap_txd[1 + 9 * CPB + CPB / 2]);
    end
    test_single(8'h55, "parity_55");
    checks++;
    if (cap_txd[1 + 9 * CPB + CPB / 2] !== 1'b0) begin
      failures++;
      $display("FAIL parity_55 parity bit: got %b need 0", cap_txd[1 + 9 * CPB + CPB / 2]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single(8'h55, "single_55");
    test_back_to_back(8'hA5, 8'h3C);
    test_ignore_busy();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
